mem_stage: RTL

- MEM pipeline stage of the five-stage MIPS core. It consumes the memory command and writeback bundle produced by the execute stage.
- It registers the bundle (EX/MEM boundary) and runs LW/SW accesses over a valid/ready data-memory bus.
- It stalls the upstream pipeline while an access is outstanding, then presents a registered writeback bundle to WB.
- Non-memory ops pass through with one cycle of latency.

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_stage.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_stage_pkg.sv
// Shared memory-op encodings and MEM stage state type.
// Also used by the execute stage to build the memory command.
package mem_stage_pkg;

  localparam logic [2:0]  MEM_NOP_OP = 3'd0;
  localparam logic [2:0]  MEM_LW_OP  = 3'd1;
  localparam logic [2:0]  MEM_SW_OP  = 3'd2;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr = 5'd0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage.sv
// MEM stage: registers the EX bundle, runs LW/SW over a valid/ready
// data bus with timeout, stalls upstream while a bus access is open.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [2:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic [4:0]  ex_write_reg,
  input  logic [31:0] ex_write_data,
  input  logic        ex_we,
  output logic        stall_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  wb_write_reg,
  output logic [31:0] wb_write_data,
  output logic        wb_we,
  output logic        exc_misalign,
  output logic        exc_bus_timeout
);

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  mem_state_t      state;
  logic [TO_W-1:0] cnt;
  logic [4:0]      acc_reg;
  logic            acc_we;

  logic is_lw;
  logic is_sw;
  logic is_mem;
  logic aligned;
  logic cnt_last;

  assign is_lw    = (mem_op == MEM_LW_OP);
  assign is_sw    = (mem_op == MEM_SW_OP);
  assign is_mem   = is_lw | is_sw;
  assign aligned  = (mem_addr[1:0] == 2'b00);
  assign cnt_last = (cnt == CNT_LAST);

  assign stall_req = (state == ACCESS) & ~dmem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      acc_reg         <= NOPRegAddr;
      acc_we          <= 1'b0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= ZeroWord;
      dmem_wdata      <= ZeroWord;
      wb_write_reg    <= NOPRegAddr;
      wb_write_data   <= ZeroWord;
      wb_we           <= 1'b0;
      exc_misalign    <= 1'b0;
      exc_bus_timeout <= 1'b0;
    end else begin
      exc_misalign    <= 1'b0;
      exc_bus_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          wb_we <= 1'b0;
          if (in_valid) begin
            unique case (1'b1)
              !is_mem: begin
                wb_write_reg  <= ex_write_reg;
                wb_write_data <= ex_write_data;
                wb_we         <= ex_we;
              end
              is_mem && !aligned: begin
                exc_misalign <= 1'b1;
              end
              default: begin
                dmem_req   <= 1'b1;
                dmem_we    <= is_sw;
                dmem_addr  <= {mem_addr[31:2], 2'b00};
                dmem_wdata <= is_sw ? mem_data : ZeroWord;
                acc_reg    <= ex_write_reg;
                acc_we     <= is_lw & ex_we;
                cnt        <= '0;
                state      <= ACCESS;
              end
            endcase
          end
        end
        ACCESS: begin
          unique case (1'b1)
            dmem_ready: begin
              dmem_req <= 1'b0;
              state    <= IDLE;
              wb_we    <= acc_we;
              if (!dmem_we) begin
                wb_write_reg  <= acc_reg;
                wb_write_data <= dmem_rdata;
              end
            end
            !dmem_ready && cnt_last: begin
              dmem_req        <= 1'b0;
              exc_bus_timeout <= 1'b1;
              wb_we           <= 1'b0;
              state           <= IDLE;
            end
            default: begin
              cnt   <= cnt + 1'b1;
              wb_we <= 1'b0;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
